uart_param: RTL
===============

// Module: uart_param
// PURPOSE
//  Parametrised full-duplex UART, successor to the fixed 8N1 UART in the SoC peripheral tier.
//  Runtime baud divisor, data width, parity and stop-bit count; oversampled, majority-voted RX.
//  Valid/ready TX handshake; RX reports data with per-frame framing and parity error flags.
//  Sits between the peripheral register bank and the pads.
// PARAMETERS
//  MAX_BITS    8   widest data field supported (5..9); data ports are MAX_BITS wide
//  OVERSAMPLE  16  baud ticks per bit (even, >=8)
//  DIV_W       16  width of baud_div
// PORTS
//  clk          in   1         system clock, single domain
//  rst_n        in   1         asynchronous active-low reset
//  baud_div     in   DIV_W     clk cycles per oversample tick; 0 behaves as 1
//  data_bits    in   4         data bits per frame, 5..MAX_BITS; out-of-range clamps to MAX_BITS
//  parity_mode  in   2         0 none, 1 even, 2 odd, 3 none
//  stop2        in   1         1 = two stop bits on TX (RX checks only the first)
//  tx_valid     in   1         TX byte offered
//  tx_ready     out  1         TX accepts when high
//  tx_data      in   MAX_BITS  TX payload, LSB sent first; bits >= data_bits ignored
//  tx           out  1         serial out, idle high
//  rx           in   1         serial in, asynchronous
//  rx_valid     out  1         one-cycle pulse: frame done (good or bad)
//  rx_data      out  MAX_BITS  received payload, zero-extended above data_bits
//  rx_frame_err out  1         qualified by rx_valid: first stop bit sampled low
//  rx_par_err   out  1         qualified by rx_valid: parity mismatch
//  tx_busy      out  1         TX state != IDLE
//  rx_busy      out  1         RX state != IDLE
// BEHAVIOUR
//  Reset: tx=1, tx_ready=1, rx_valid=0, rx_data=0, both err flags 0, both busy 0, all FSMs IDLE.
//  Reset mid-frame aborts immediately; tx returns high asynchronously.
//  Tick: free-running counter pulses tick once every max(baud_div,1) clk; shared by TX and RX.
//  baud_div change takes effect at the next counter wrap. No frame realignment.
//  Config (data_bits, parity_mode, stop2) is latched at frame start; changes mid-frame are ignored.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each bit lasts OVERSAMPLE ticks.
//   - Handshake completes when tx_valid & tx_ready on a clk edge; data is latched then.
//   - tx_ready drops the next cycle and stays low until the last stop tick has elapsed.
//   - START is then aligned to the next tick.
//   - Parity: even = XOR of data bits; odd = its inverse. STOP lasts 1 or 2 bit times.
//   - Back-to-back: tx_valid held high sends the next frame with no idle gap beyond the stop bit(s).
//  RX: 2-flop synchroniser on rx; all logic uses the synchronised copy.
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: a high-to-low edge on a tick resets the tick count.
//   - START: at OVERSAMPLE/2 ticks the majority must be 0, else return to IDLE silently (glitch reject).
//   - Each subsequent bit is sampled as a majority of 3 samples on ticks mid-1, mid, mid+1.
//     Bit centres are spaced OVERSAMPLE ticks apart.
//   - STOP: after the mid-bit sample, rx_valid pulses 1 clk with data and flags.
//     FSM returns to IDLE and accepts a new start edge immediately (no restart delay).
//  Latency: rx_valid occurs at most 2 synchroniser clks + 1 clk after the stop-bit mid-sample.
//  Error frames still deliver rx_data; no overrun detection (consumer must take data on rx_valid).
//  TX and RX are independent; simultaneous activity in both directions is fully supported.
// STRUCTURE
//  Shared package uart_pkg: FSM state encodings (IDLE/START/DATA/PARITY/STOP), parity_mode codes.
//  Sub-module uart_baud_gen: tick counter (baud_div in, tick out), one instance shared by TX and RX.
//  TX and RX FSMs live in this module.
// TESTING
//  1. baud_div=4, 8N1, send 0xA5 -> tx low 64 clk, then bits 1,0,1,0,0,1,0,1 at 64 clk each, then high.
//  2. Loopback tx->rx, 7E2 and 8O1, all values 0..max -> rx_data matches, both error flags 0.
//  3. rx stop bit forced low, 8N1 0x3C -> rx_valid with rx_data=0x3C, rx_frame_err=1.
//     Next frame then received cleanly.
//  4. Flip parity bit in 8E1 frame -> rx_par_err=1, rx_frame_err=0.
//     Single-tick glitch on a data-bit centre -> no error (majority vote).
//  5. rx low pulse of OVERSAMPLE/4 ticks while idle -> no rx_valid; rx_busy returns to 0.
//  6. rst_n asserted mid TX data bit -> tx=1, tx_ready=1 asynchronously.
//     After release, new frame sent correctly. tx_valid held 3 frames -> no gaps beyond stop bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART.
//   uart_state_e : FSM state encoding used by both the TX and RX machines
//   ParEven/ParOdd : parity_mode codes; the remaining codes (0, 3) mean no parity
//   par_enabled  : true when a parity bit is present in the frame
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [1:0] ParEven = 2'd1;
  localparam logic [1:0] ParOdd  = 2'd2;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == ParEven) || (mode == ParOdd);
  endfunction

endpackage

// File: rtl/uart_param_if.sv
// Register-bank side of the UART: TX valid/ready payload handshake and RX result signals.
//   master : register bank (drives tx_valid/tx_data, consumes RX results)
//   slave  : the UART itself
interface uart_param_if #(
  parameter int unsigned MAX_BITS = 8
);

  logic                tx_valid;
  logic                tx_ready;
  logic [MAX_BITS-1:0] tx_data;
  logic                rx_valid;
  logic [MAX_BITS-1:0] rx_data;
  logic                rx_frame_err;
  logic                rx_par_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, rx_valid, rx_data, rx_frame_err, rx_par_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, rx_valid, rx_data, rx_frame_err, rx_par_err
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator shared by TX and RX.
//   clk, rst_n : clock, async active-low reset
//   baud_div   : clk cycles per tick (0 behaves as 1), sampled only at counter wrap
//   tick       : one-clk pulse every max(baud_div,1) clks
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    // div_q is never zero, so the subtraction cannot wrap
    tick  = (cnt_q >= div_q - DivOne);
    cnt_d = cnt_q + DivOne;
    div_d = div_q;
    if (tick) begin
      cnt_d = '0;
      div_d = (baud_div == '0) ? DivOne : baud_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      div_q <= DivOne;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: runtime divisor, 5..MAX_BITS data bits, parity, 1/2 stop bits,
// oversampled majority-voted RX.
//   clk, rst_n   : single clock, async active-low reset
//   baud_div     : clk cycles per oversample tick
//   data_bits, parity_mode, stop2 : frame format, latched at frame start
//   bus          : TX handshake/payload and RX results (slave side)
//   tx, rx       : serial pads (rx asynchronous)
//   tx_busy, rx_busy : FSM not idle
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned MAX_BITS   = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  uart_param_if.slave      bus,
  output logic             tx,
  input  logic             rx,
  output logic             tx_busy,
  output logic             rx_busy
);

  localparam int unsigned   CntW     = $clog2(OVERSAMPLE);
  localparam int unsigned   Mid      = OVERSAMPLE / 2;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntMidM = CntW'(Mid - 1);
  localparam logic [CntW-1:0] CntMid  = CntW'(Mid);
  localparam logic [CntW-1:0] CntMidP = CntW'(Mid + 1);
  localparam logic [3:0]      MaxBits = 4'(MAX_BITS);

  logic tick;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // Effective data width and payload mask for a frame starting now
  logic [3:0]          nb_cfg;
  logic [MAX_BITS-1:0] mask_cfg;
  always_comb begin
    nb_cfg   = (data_bits < 4'd5 || data_bits > MaxBits) ? MaxBits : data_bits;
    mask_cfg = ~({MAX_BITS{1'b1}} << nb_cfg);
  end

  // ---------------------------------------------------------------- TX
  uart_state_e         tx_st_q, tx_st_d;
  logic [CntW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [MAX_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]          tx_idx_q, tx_idx_d, tx_nb_q, tx_nb_d;
  logic tx_arm_q, tx_arm_d, tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
  logic tx_stop2_q, tx_stop2_d, tx_stop_q, tx_stop_d, tx_q, tx_d;
  logic tx_bit_end, tx_last, tx_accept;

  always_comb begin
    // tx_arm_q: frame accepted from idle, waiting for the tick that starts the start bit
    tx_bit_end   = tick && !tx_arm_q && (tx_cnt_q == CntLast);
    tx_last      = (tx_st_q == StStop) && tx_bit_end && (!tx_stop2_q || tx_stop_q);
    // Ready on the final stop tick lets a held tx_valid chain frames with no gap
    bus.tx_ready = (tx_st_q == StIdle) || tx_last;
    tx_accept    = bus.tx_valid && bus.tx_ready;

    tx_st_d = tx_st_q;  tx_cnt_d = tx_cnt_q;  tx_shift_d = tx_shift_q;
    tx_idx_d = tx_idx_q;  tx_nb_d = tx_nb_q;  tx_arm_d = tx_arm_q;
    tx_par_en_d = tx_par_en_q;  tx_par_d = tx_par_q;
    tx_stop2_d = tx_stop2_q;  tx_stop_d = tx_stop_q;

    if (tick && !tx_arm_q && tx_st_q != StIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CntOne;

    case (tx_st_q)
      StStart: begin
        if (tick && tx_arm_q) tx_arm_d = 1'b0;
        if (tx_bit_end) begin
          tx_st_d  = StData;
          tx_idx_d = '0;
        end
      end
      StData: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_idx_q == tx_nb_q - 4'd1) tx_st_d = tx_par_en_q ? StParity : StStop;
        else                            tx_idx_d = tx_idx_q + 4'd1;
      end
      StParity: if (tx_bit_end) tx_st_d = StStop;
      StStop: if (tx_bit_end) begin
        if (tx_stop2_q && !tx_stop_q) tx_stop_d = 1'b1;
        else                          tx_st_d   = StIdle;
      end
      default: tx_st_d = StIdle;
    endcase

    if (tx_accept) begin
      tx_st_d     = StStart;
      tx_arm_d    = (tx_st_q == StIdle);  // chained frames start on this very tick
      tx_cnt_d    = '0;
      tx_stop_d   = 1'b0;
      tx_shift_d  = bus.tx_data & mask_cfg;
      tx_nb_d     = nb_cfg;
      tx_par_en_d = par_enabled(parity_mode);
      tx_par_d    = (^(bus.tx_data & mask_cfg)) ^ (parity_mode == ParOdd);
      tx_stop2_d  = stop2;
    end

    case (tx_st_d)
      StStart:  tx_d = tx_arm_d;
      StData:   tx_d = tx_shift_d[0];
      StParity: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= StIdle;  tx_cnt_q <= '0;  tx_shift_q <= '0;  tx_idx_q <= '0;  tx_nb_q <= '0;
      tx_arm_q <= 1'b0;  tx_par_en_q <= 1'b0;  tx_par_q <= 1'b0;  tx_stop2_q <= 1'b0;
      tx_stop_q <= 1'b0;  tx_q <= 1'b1;
    end else begin
      tx_st_q <= tx_st_d;  tx_cnt_q <= tx_cnt_d;  tx_shift_q <= tx_shift_d;  tx_idx_q <= tx_idx_d;
      tx_nb_q <= tx_nb_d;  tx_arm_q <= tx_arm_d;  tx_par_en_q <= tx_par_en_d;  tx_par_q <= tx_par_d;
      tx_stop2_q <= tx_stop2_d;  tx_stop_q <= tx_stop_d;  tx_q <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (tx_st_q != StIdle);

  // ---------------------------------------------------------------- RX
  uart_state_e         rx_st_q, rx_st_d;
  logic [CntW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [MAX_BITS-1:0] rx_acc_q, rx_acc_d, rx_data_q, rx_data_d;
  logic [3:0]          rx_idx_q, rx_idx_d, rx_nb_q, rx_nb_d;
  logic [1:0]          rx_vote_q, rx_vote_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_prev_d, rx_par_en_q, rx_par_en_d;
  logic rx_odd_q, rx_odd_d, rx_parx_q, rx_parx_d, rx_perr_q, rx_perr_d;
  logic rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d, rx_perr_o_q, rx_perr_o_d;
  logic rx_maj, rx_decide, rx_bit_end;

  always_comb begin
    // Vote over samples at mid-1, mid and the current (mid+1) tick
    rx_maj     = (rx_vote_q[1] & rx_vote_q[0]) | (rx_vote_q[1] & rx_s2_q) |
                 (rx_vote_q[0] & rx_s2_q);
    rx_decide  = tick && (rx_cnt_q == CntMidP);
    rx_bit_end = tick && (rx_cnt_q == CntLast);

    rx_st_d = rx_st_q;  rx_cnt_d = rx_cnt_q;  rx_acc_d = rx_acc_q;  rx_data_d = rx_data_q;
    rx_idx_d = rx_idx_q;  rx_nb_d = rx_nb_q;  rx_vote_d = rx_vote_q;  rx_prev_d = rx_prev_q;
    rx_par_en_d = rx_par_en_q;  rx_odd_d = rx_odd_q;  rx_parx_d = rx_parx_q;
    rx_perr_d = rx_perr_q;  rx_ferr_d = rx_ferr_q;  rx_perr_o_d = rx_perr_o_q;
    rx_valid_d = 1'b0;

    if (tick) begin
      rx_prev_d = rx_s2_q;
      if (rx_st_q != StIdle) rx_cnt_d = (rx_cnt_q == CntLast) ? '0 : rx_cnt_q + CntOne;
      if (rx_cnt_q == CntMidM || rx_cnt_q == CntMid) rx_vote_d = {rx_vote_q[0], rx_s2_q};
    end

    case (rx_st_q)
      StIdle: if (tick && rx_prev_q && !rx_s2_q) begin
        rx_st_d = StStart;  rx_cnt_d = '0;  rx_idx_d = '0;  rx_nb_d = nb_cfg;
        rx_par_en_d = par_enabled(parity_mode);  rx_odd_d = (parity_mode == ParOdd);
        rx_acc_d = '0;  rx_parx_d = 1'b0;  rx_perr_d = 1'b0;
      end
      StStart: begin
        if (rx_decide && rx_maj) rx_st_d = StIdle;  // glitch, not a start bit
        else if (rx_bit_end)     rx_st_d = StData;
      end
      StData: begin
        if (rx_decide) begin
          rx_acc_d  = rx_acc_q | (MAX_BITS'(rx_maj) << rx_idx_q);
          rx_parx_d = rx_parx_q ^ rx_maj;
        end
        if (rx_bit_end) begin
          if (rx_idx_q == rx_nb_q - 4'd1) rx_st_d = rx_par_en_q ? StParity : StStop;
          else                            rx_idx_d = rx_idx_q + 4'd1;
        end
      end
      StParity: begin
        if (rx_decide)  rx_perr_d = rx_maj ^ rx_parx_q ^ rx_odd_q;
        if (rx_bit_end) rx_st_d   = StStop;
      end
      StStop: if (rx_decide) begin
        rx_valid_d  = 1'b1;
        rx_data_d   = rx_acc_q;
        rx_ferr_d   = !rx_maj;
        rx_perr_o_d = rx_perr_q;
        rx_st_d     = StIdle;
      end
      default: rx_st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;  rx_st_q <= StIdle;
      rx_cnt_q <= '0;  rx_acc_q <= '0;  rx_data_q <= '0;  rx_idx_q <= '0;  rx_nb_q <= '0;
      rx_vote_q <= '0;  rx_par_en_q <= 1'b0;  rx_odd_q <= 1'b0;  rx_parx_q <= 1'b0;
      rx_perr_q <= 1'b0;  rx_valid_q <= 1'b0;  rx_ferr_q <= 1'b0;  rx_perr_o_q <= 1'b0;
    end else begin
      rx_s1_q <= rx;  rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_prev_d;  rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;  rx_acc_q <= rx_acc_d;  rx_data_q <= rx_data_d;
      rx_idx_q <= rx_idx_d;  rx_nb_q <= rx_nb_d;  rx_vote_q <= rx_vote_d;
      rx_par_en_q <= rx_par_en_d;  rx_odd_q <= rx_odd_d;  rx_parx_q <= rx_parx_d;
      rx_perr_q <= rx_perr_d;  rx_valid_q <= rx_valid_d;  rx_ferr_q <= rx_ferr_d;
      rx_perr_o_q <= rx_perr_o_d;
    end
  end

  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_frame_err = rx_ferr_q;
  assign bus.rx_par_err   = rx_perr_o_q;
  assign rx_busy          = (rx_st_q != StIdle);

endmodule
